// File: rtl/blink_pkg.sv
// Shared encodings for the blink controller slice.
// Mode, config-FSM state and tick-bit constants.
package blink_pkg;

    localparam logic [1:0] MODE_OFF    = 2'd0;
    localparam logic [1:0] MODE_STEADY = 2'd1;
    localparam logic [1:0] MODE_BLINK  = 2'd2;
    localparam logic [1:0] MODE_CHASE  = 2'd3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LATCH = 2'd1;
    localparam logic [1:0] ST_SYNC  = 2'd2;

    localparam int TICK_BIT = 9;

    function automatic logic mode_gate(
        input logic [1:0] mode,
        input logic       hit
    );
        logic g;
        case (mode)
            MODE_OFF:    g = 1'b0;
            MODE_STEADY: g = 1'b1;
            MODE_BLINK:  g = 1'b1;
            MODE_CHASE:  g = hit;
            default:     g = 1'b0;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/blink_counter.sv
// Shared free-running blink counter, tick strobe
// and chase pointer for the blink controller.
module blink_counter
    import blink_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_ena,
    input  logic                      i_run,
    output logic [CNT_W-1:0]          o_count,
    output logic                      o_tick,
    output logic [$clog2(NUM_CH)-1:0] o_ptr
);

    localparam int PTR_W = $clog2(NUM_CH);

    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] r_ptr;
    logic             w_adv;

    assign w_adv   = i_run & i_ena;
    assign o_tick  = w_adv & (&r_count[TICK_BIT:0]);
    assign o_count = r_count;
    assign o_ptr   = r_ptr;

    // Count up while enabled; wraps naturally at full scale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_adv) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Step the chase pointer once per tick, wrapping at the last channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (o_tick) begin
            if (r_ptr == PTR_W'(NUM_CH - 1)) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= r_ptr + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/blink_controller.sv
// Blink controller top: config handshake FSM, per-channel
// mode/offset registers and registered output gates.
module blink_controller
    import blink_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ena,
    input  logic                      run,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
    input  logic [1:0]                cfg_mode,
    input  logic [CNT_W-1:0]          cfg_offset,
    output logic [CNT_W-1:0]          current_count,
    output logic [NUM_CH*CNT_W-1:0]   ch_offset,
    output logic [NUM_CH-1:0]         ch_enable,
    output logic                      busy
);

    localparam int PTR_W = $clog2(NUM_CH);

    logic             w_tick;
    logic [PTR_W-1:0] w_ptr;
    logic             w_accept;
    logic             w_commit;
    logic             w_live;

    logic [1:0]       r_state;
    logic             r_first;
    logic             r_rdy;
    logic [PTR_W-1:0] r_sh_ch;
    logic [1:0]       r_sh_mode;
    logic [CNT_W-1:0] r_sh_off;
    logic [1:0]       r_mode [NUM_CH];
    logic [CNT_W-1:0] r_off  [NUM_CH];
    logic [NUM_CH-1:0] r_en;

    blink_counter #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W)
    ) u_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_ena   (ena),
        .i_run   (run),
        .o_count (current_count),
        .o_tick  (w_tick),
        .o_ptr   (w_ptr)
    );

    assign w_live    = run & ena;
    assign cfg_ready = r_rdy & (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign w_accept  = cfg_valid & cfg_ready;
    // A stopped counter never ticks, so commit at once on SYNC entry.
    assign w_commit  = (r_state == ST_SYNC) &
                       (w_tick | (r_first & ~w_live));
    assign ch_enable = r_en;

    // Hold cfg_ready low through reset and for the release cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy <= 1'b0;
        end else begin
            r_rdy <= 1'b1;
        end
    end

    // Config FSM: IDLE accepts, LATCH settles, SYNC waits for commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_first <= 1'b0;
        end else begin
            unique case (1'b1)
                (r_state == ST_IDLE): begin
                    r_first <= 1'b0;
                    if (w_accept) begin
                        r_state <= ST_LATCH;
                    end
                end
                (r_state == ST_LATCH): begin
                    r_state <= ST_SYNC;
                    r_first <= 1'b1;
                end
                (r_state == ST_SYNC): begin
                    r_first <= 1'b0;
                    if (w_commit) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_first <= 1'b0;
                end
            endcase
        end
    end

    // Capture the accepted request into the shadow register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_ch   <= '0;
            r_sh_mode <= MODE_OFF;
            r_sh_off  <= '0;
        end else if (w_accept) begin
            r_sh_ch   <= cfg_ch;
            r_sh_mode <= cfg_mode;
            r_sh_off  <= cfg_offset;
        end
    end

    // Commit the shadow into the addressed channel only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_mode[i] <= MODE_OFF;
                r_off[i]  <= '0;
            end
        end else if (w_commit) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (r_sh_ch == PTR_W'(i)) begin
                    r_mode[i] <= r_sh_mode;
                    r_off[i]  <= r_sh_off;
                end
            end
        end
    end

    // Register each output gate from its mode and the chase pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_en[i] <= mode_gate(r_mode[i], w_ptr == PTR_W'(i));
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_off
        assign ch_offset[g*CNT_W +: CNT_W] = r_off[g];
    end

endmodule

// File: tb/tb_blink_controller.sv
// Directed self-checking bench for blink_controller.
// Hand-computed expectations; all compares via check().
module tb_blink_controller;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b0;
    logic        run = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_ch = '0;
    logic [1:0]  cfg_mode = '0;
    logic [15:0] cfg_offset = '0;
    logic [15:0] current_count;
    logic [63:0] ch_offset;
    logic [3:0]  ch_enable;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    blink_controller #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ena           (ena),
        .run           (run),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_ch        (cfg_ch),
        .cfg_mode      (cfg_mode),
        .cfg_offset    (cfg_offset),
        .current_count (current_count),
        .ch_offset     (ch_offset),
        .ch_enable     (ch_enable),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h",
                     tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] off(input int i);
        return ch_offset[i*16 +: 16];
    endfunction

    task automatic wait_count(input logic [15:0] tgt,
                              input int limit,
                              input string tag);
        int n = 0;
        while (current_count !== tgt && n < limit) begin
            step();
            n++;
        end
        check(tag, {48'h0, current_count}, {48'h0, tgt});
    endtask

    task automatic put(input logic [1:0] ch,
                       input logic [1:0] md,
                       input logic [15:0] of);
        cfg_valid  = 1'b1;
        cfg_ch     = ch;
        cfg_mode   = md;
        cfg_offset = of;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  bp_ch  [3];
        logic [1:0]  bp_md  [3];
        logic [15:0] bp_of  [3];
        logic [15:0] t_cnt  [4];
        logic [3:0]  t_en   [4];
        logic [3:0]  prev;
        logic        bad;
        int          n;

        bp_ch = '{2'd0, 2'd1, 2'd3};
        bp_md = '{2'd2, 2'd0, 2'd3};
        bp_of = '{16'h0011, 16'h0022, 16'h0033};
        t_cnt = '{16'h07FF, 16'h0BFF, 16'h0FFF, 16'h13FF};
        t_en  = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};

        // reset state
        repeat (2) step();
        check("rst count", current_count, 0);
        check("rst offset", ch_offset, 0);
        check("rst enable", ch_enable, 0);
        check("rst ready", cfg_ready, 0);
        check("rst busy", busy, 0);
        rst_n = 1'b1;
        check("rel ready pre", cfg_ready, 0);
        step();
        check("rel ready", cfg_ready, 1);

        // reset mid-count with SYNC pending
        ena = 1'b1;
        run = 1'b1;
        wait_count(16'h1200, 5000, "cnt 1200");
        put(2'd0, 2'd1, 16'h00AA);
        step();
        cfg_valid = 1'b0;
        check("pend busy", busy, 1);
        wait_count(16'h1234, 100, "cnt 1234");
        check("pend still busy", busy, 1);
        check("pend no commit", off(0), 0);
        rst_n = 1'b0;
        #1;
        check("mid rst count", current_count, 0);
        check("mid rst offset", ch_offset, 0);
        check("mid rst enable", ch_enable, 0);
        check("mid rst ready", cfg_ready, 0);
        check("mid rst busy", busy, 0);
        run = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        check("mid rel ready", cfg_ready, 1);
        step();
        check("mid rel offset", ch_offset, 0);
        check("mid rel enable", ch_enable, 0);
        check("mid rel count", current_count, 0);

        // idle commit, run low
        put(2'd2, 2'd1, 16'h0055);
        check("idle ready", cfg_ready, 1);
        step();
        cfg_valid = 1'b0;
        check("idle acc busy", busy, 1);
        check("idle acc ready", cfg_ready, 0);
        check("idle acc off", off(2), 0);
        step();
        check("idle latch off", off(2), 0);
        step();
        check("idle commit off", off(2), 16'h0055);
        check("idle commit ready", cfg_ready, 1);
        check("idle commit en", ch_enable, 0);
        step();
        check("idle en", ch_enable, 4'b0100);

        // back-pressure, valid held across three requests
        for (int k = 0; k < 3; k++) begin
            put(bp_ch[k], bp_md[k], bp_of[k]);
            check($sformatf("bp ready %0d", k), cfg_ready, 1);
            step();
            check($sformatf("bp busy %0d", k), busy, 1);
            step();
            check($sformatf("bp hold %0d", k), cfg_ready, 0);
            step();
            check($sformatf("bp off %0d", k),
                  off(int'(bp_ch[k])), bp_of[k]);
        end
        cfg_valid = 1'b0;
        step();
        check("bp idle", busy, 0);
        check("bp all off", ch_offset, 64'h0033_0055_0022_0011);
        check("bp en", ch_enable, 4'b0101);

        // commit synchronised to tick
        run = 1'b1;
        wait_count(16'h0100, 300, "cnt 0100");
        put(2'd1, 2'd2, 16'h0200);
        step();
        cfg_valid = 1'b0;
        bad = 1'b0;
        n = 0;
        while (current_count !== 16'h03FF && n < 1000) begin
            if (busy !== 1'b1 || off(1) !== 16'h0022) bad = 1'b1;
            step();
            n++;
        end
        check("sync window", bad, 0);
        check("sync at 3ff", current_count, 16'h03FF);
        check("sync 3ff busy", busy, 1);
        check("sync 3ff off", off(1), 16'h0022);
        step();
        check("sync cnt 400", current_count, 16'h0400);
        check("sync commit off", off(1), 16'h0200);
        check("sync commit busy", busy, 0);
        check("sync commit ready", cfg_ready, 1);
        step();
        check("sync en", ch_enable, 4'b0111);

        // chase across all channels
        run = 1'b0;
        for (int i = 0; i < 4; i++) begin
            put(2'(i), 2'd3, 16'h1000 + 16'(i));
            step();
            cfg_valid = 1'b0;
            step();
            step();
        end
        step();
        check("chase offs", ch_offset, 64'h1003_1002_1001_1000);
        check("chase start", ch_enable, 4'b0010);
        prev = 4'b0010;
        run = 1'b1;
        for (int j = 0; j < 4; j++) begin
            wait_count(t_cnt[j], 1100, $sformatf("chase cnt %0d", j));
            check($sformatf("chase pre %0d", j), ch_enable, prev);
            step();
            check($sformatf("chase lag %0d", j), ch_enable, prev);
            step();
            check($sformatf("chase en %0d", j), ch_enable, t_en[j]);
            prev = t_en[j];
        end

        // counter wrap and tick at wrap
        wait_count(16'hFFFE, 61000, "cnt fffe");
        check("wrap pre en", ch_enable, 4'b1000);
        step();
        check("wrap ffff", current_count, 16'hFFFF);
        step();
        check("wrap 0000", current_count, 16'h0000);
        check("wrap lag en", ch_enable, 4'b1000);
        step();
        check("wrap en", ch_enable, 4'b0001);
        wait_count(16'h03FF, 1100, "cnt 03ff");
        step();
        check("tick cnt 400", current_count, 16'h0400);
        step();
        check("tick en", ch_enable, 4'b0010);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/blink_controller.md
BLINK_CONTROLLER -- requirements
Module: blink_controller

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of blinker channels controlled (2..8).
REQ-002 SHALL have parameter CNT_W, default 16, width of the shared blink counter and of each offset.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port ena  input  1  global enable; counter and chase pointer hold while low.
REQ-006 SHALL have port run  input  1  counter run request; counting requires run and ena.
REQ-007 SHALL have port cfg_valid  input  1  config request valid.
REQ-008 SHALL have port cfg_ready  output  1  controller can accept config.
REQ-009 SHALL have port cfg_ch  input  $clog2(NUM_CH)  target channel.
REQ-010 SHALL have port cfg_mode  input  2  mode: 0 OFF, 1 STEADY, 2 BLINK, 3 CHASE.
REQ-011 SHALL have port cfg_offset  input  CNT_W  offset for target channel.
REQ-012 SHALL have port current_count  output  CNT_W  shared free-running count to all blinkers.
REQ-013 SHALL have port ch_offset  output  NUM_CH*CNT_W  per-channel offsets, channel i at bits [i*CNT_W +: CNT_W].
REQ-014 SHALL have port ch_enable  output  NUM_CH  per-channel output gate.
REQ-015 SHALL have port busy  output  1  config pending (state not IDLE).

Function
REQ-016 SHALL advance current_count by 1 per cycle when run&ena, wrap 2^CNT_W-1 -> 0, and hold otherwise.
REQ-017 SHALL define tick as a cycle where current_count[9:0]==0x3FF and the counter advances.
REQ-018 SHALL implement states IDLE, LATCH, SYNC; cfg_ready=1 only in IDLE; busy=~cfg_ready.
REQ-019 SHALL accept a request on clk edge with cfg_valid&cfg_ready, capture ch/mode/offset into a shadow register, go IDLE->LATCH.
REQ-020 SHALL go LATCH->SYNC unconditionally after one cycle.
REQ-021 SHALL, in SYNC, commit the shadow into channel cch's mode and ch_offset on a tick, or in the first SYNC cycle if run&ena is low, then return to IDLE.
REQ-022 SHALL keep channel registers unchanged until commit; cfg_valid outside IDLE is ignored, and a held request is accepted on the first IDLE cycle.
REQ-023 SHALL give minimum accept-to-commit latency 2 cycles (accept, LATCH, commit edge); cfg_ready re-asserts the cycle after commit.
REQ-024 SHALL maintain chase pointer ptr (range 0..NUM_CH-1), advancing on each tick and wrapping NUM_CH-1 -> 0.
REQ-025 SHALL register ch_enable[i]: OFF->0, STEADY->1, BLINK->1, CHASE->(ptr==i); updates one cycle after the mode or ptr change.
REQ-026 SHALL, for a commit and a ptr advance on the same tick, apply both; ch_enable reflects new mode with new ptr.
REQ-027 SHALL leave the ch_offset of a channel written to OFF at the new cfg_offset value.
REQ-028 SHALL ignore ena/run deassertion in SYNC except per REQ-021.

Reset
REQ-029 SHALL, while rst_n=0: current_count=0, ptr=0, all modes OFF, ch_offset=0, ch_enable=0, shadow=0, state=IDLE.
REQ-030 SHALL hold cfg_ready=0 during reset and 1 from the first edge after rst_n rises; mid-transaction reset discards pending config.

Structure
REQ-031 SHALL place mode encodings (OFF/STEADY/BLINK/CHASE), state encodings, and tick bit index (9) in shared package blink_pkg.
REQ-032 SHALL instantiate one sub-module, blink_counter (counter, tick, chase pointer), with config FSM and channel registers in blink_controller.

Verification
REQ-033 SHALL verify reset: rst_n low mid-count 0x1234 with SYNC pending -> all outputs 0 immediately, cfg_ready=1 one edge after release, no commit.
REQ-034 SHALL verify wrap: count forced to 0xFFFE, run=ena=1 -> 0xFFFF then 0x0000, tick on 0x03FF->0x0400.
REQ-035 SHALL verify sync commit: run at count 0x0100, write ch1 BLINK off 0x0200 -> ch_offset[1] changes at 0x0400, busy high 0x0101..0x03FF.
REQ-036 SHALL verify idle commit: run=0, write ch2 STEADY -> commit 2 cycles after accept, ch_enable[2]=1 next cycle.
REQ-037 SHALL verify chase: all 4 channels CHASE, run -> ch_enable 0001, 0010, 0100, 1000, 0001 every 1024 cycles.
REQ-038 SHALL verify back-pressure: cfg_valid held 3 requests -> each accepted only in IDLE, committed in order, none dropped.
